// File: rtl/intr_pkg.sv
// rtl/intr_pkg.sv - shared types and defaults for the interrupt conditioner
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } ch_state_e;

    localparam int DEF_N_CH            = 8;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_PULSE_CYCLES    = 2;
    localparam int DEF_HOLDOFF_CYCLES  = 8;

    // Counter width for a count of 'value' cycles, never narrower than one bit.
    function automatic int cnt_width(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/intr_channel.sv
// rtl/intr_channel.sv - one channel: synchronizer, debounce, pulse FSM, pending and overrun
module intr_channel
    import intr_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic req_in,
    input  logic enable,
    input  logic clr_overrun,
    output logic intr_out,
    output logic pending,
    output logic overrun
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int PW = cnt_width(PULSE_CYCLES);
    localparam int HW = cnt_width(HOLDOFF_CYCLES);

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(PULSE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(HOLDOFF_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   f_q;
    logic [DW-1:0]          cnt_q;
    ch_state_e              state_q;
    logic [PW-1:0]          pcnt_q;
    logic [HW-1:0]          hcnt_q;
    logic                   intr_q;
    logic                   pend_q;
    logic                   ovr_q;
    logic                   evt;
    logic                   pend_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_q   <= 1'b0;
            cnt_q <= '0;
        end else if (s == f_q) begin
            cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
            f_q   <= s;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // An event is the edge on which the filtered level is about to rise.
    assign evt = s && !f_q && (cnt_q == DB_LAST) && enable;

    // Queue contents while busy: a held event survives only while enabled.
    assign pend_d = (pend_q && enable) || evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            hcnt_q  <= '0;
            intr_q  <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= (evt && pend_q) || (ovr_q && !clr_overrun);
            case (state_q)
                IDLE: begin
                    pend_q <= 1'b0;
                    if (evt) begin
                        state_q <= PULSE;
                        pcnt_q  <= P_LAST;
                        intr_q  <= 1'b1;
                    end
                end
                PULSE: begin
                    pend_q <= pend_d;
                    if (pcnt_q == '0) begin
                        state_q <= HOLDOFF;
                        hcnt_q  <= H_LAST;
                        intr_q  <= 1'b0;
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (hcnt_q == '0) begin
                        // An event arriving on the expiry edge is served at once.
                        pend_q <= 1'b0;
                        if (pend_d) begin
                            state_q <= PULSE;
                            pcnt_q  <= P_LAST;
                            intr_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        pend_q <= pend_d;
                        hcnt_q <= hcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    intr_q  <= 1'b0;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    assign intr_out = intr_q;
    assign pending  = pend_q;
    assign overrun  = ovr_q;

endmodule

// File: rtl/intr_conditioner.sv
// rtl/intr_conditioner.sv - conditions N_CH raw request lines into CPU interrupt pulses
module intr_conditioner
    import intr_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] req_in,
    input  logic [N_CH-1:0] enable,
    input  logic [N_CH-1:0] clr_overrun,
    output logic [N_CH-1:0] intr_out,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overrun
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        intr_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PULSE_CYCLES    (PULSE_CYCLES),
            .HOLDOFF_CYCLES  (HOLDOFF_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .req_in      (req_in[i]),
            .enable      (enable[i]),
            .clr_overrun (clr_overrun[i]),
            .intr_out    (intr_out[i]),
            .pending     (pending[i]),
            .overrun     (overrun[i])
        );
    end

endmodule

// File: tb/tb_intr_conditioner.sv
// tb/tb_intr_conditioner.sv - directed self-checking bench for intr_conditioner
module tb_intr_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req_in;
    logic [7:0] enable;
    logic [7:0] clr_overrun;
    logic [7:0] intr_out;
    logic [7:0] pending;
    logic [7:0] overrun;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    intr_conditioner #(.N_CH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .enable      (enable),
        .clr_overrun (clr_overrun),
        .intr_out    (intr_out),
        .pending     (pending),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic watch(input int ch, input int n, output int rises, output int highs);
        logic prev;
        prev  = intr_out[ch];
        rises = 0;
        highs = 0;
        repeat (n) begin
            @(negedge clk);
            if (intr_out[ch]) highs++;
            if (intr_out[ch] && !prev) rises++;
            prev = intr_out[ch];
        end
    endtask

    initial begin
        int   r;
        int   h;
        int   first;
        int   second;
        logic prev;

        reset       = 1'b1;
        req_in      = 8'h00;
        enable      = 8'hFF;
        clr_overrun = 8'h00;
        #2 reset = 1'b0;
        cycles(3);
        check("rst_intr", intr_out, 8'h00);
        check("rst_pend", pending, 8'h00);
        check("rst_ovr", overrun, 8'h00);
        reset = 1'b1;
        cycles(3);

        // Basic pulse on channel 0: edge E0 follows this drive.
        req_in[0] = 1'b1;
        cycles(5);
        check("t1_e4", intr_out, 8'h00);
        cycles(1);
        check("t1_e5", intr_out, 8'h01);
        cycles(1);
        check("t1_e6", intr_out, 8'h01);
        check("t1_pend", pending, 8'h00);
        check("t1_ovr", overrun, 8'h00);
        cycles(1);
        check("t1_e7", intr_out, 8'h00);
        req_in[0] = 1'b0;
        cycles(20);

        // Glitch rejection on channel 3.
        req_in[3] = 1'b1;
        cycles(3);
        req_in[3] = 1'b0;
        watch(3, 20, r, h);
        check("glitch_hi", h, 0);
        req_in[3] = 1'b1;
        cycles(4);
        req_in[3] = 1'b0;
        watch(3, 20, r, h);
        check("db4_pulses", r, 1);
        check("db4_width", h, 2);

        // Square wave of period 8 on channel 1: events at E5, E13, E21, ...
        first  = -1;
        second = -1;
        prev   = 1'b0;
        for (int k = 0; k < 48; k++) begin
            req_in[1] = ((k % 8) < 4);
            @(negedge clk);
            if (intr_out[1] && !prev) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            prev = intr_out[1];
            if (k == 13) check("pend_b", pending[1], 1);
        end
        req_in[1] = 1'b0;
        check("a_start", first, 5);
        check("b_gap", second - first, 10);
        check("ovr_set", overrun, 8'h02);
        cycles(30);
        check("ovr_sticky", overrun, 8'h02);
        check("pend_idle", pending, 8'h00);
        clr_overrun[1] = 1'b1;
        cycles(1);
        clr_overrun[1] = 1'b0;
        check("ovr_clr", overrun, 8'h00);

        // Same wave again; the overrun edge E45 coincides with a clear.
        for (int k = 0; k < 48; k++) begin
            req_in[1]      = ((k % 8) < 4);
            clr_overrun[1] = (k == 45);
            @(negedge clk);
            if (k == 44) check("ovr_pre", overrun[1], 0);
            if (k == 45) check("ovr_set_wins", overrun[1], 1);
        end
        req_in[1]      = 1'b0;
        clr_overrun[1] = 1'b0;
        cycles(30);

        // Enable masking on channel 2.
        enable[2] = 1'b0;
        req_in[2] = 1'b1;
        watch(2, 12, r, h);
        check("mask_hi", h, 0);
        check("mask_pend", pending[2], 0);
        req_in[2] = 1'b0;
        cycles(12);
        enable[2] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            req_in[2] = ((k % 8) < 4);
            @(negedge clk);
        end
        check("pend2_set", pending[2], 1);
        req_in[2] = 1'b0;
        enable[2] = 1'b0;
        cycles(1);
        check("pend2_clr", pending[2], 0);
        watch(2, 20, r, h);
        check("pend2_nopulse", r, 0);
        enable[2] = 1'b1;

        // Reset in the middle of a channel 5 pulse.
        req_in[5] = 1'b1;
        cycles(6);
        check("t5_pulse", intr_out[5], 1);
        reset = 1'b0;
        #1;
        check("t5_rst_intr", intr_out, 8'h00);
        check("t5_rst_pend", pending, 8'h00);
        check("t5_rst_ovr", overrun, 8'h00);
        cycles(2);
        reset = 1'b1;
        cycles(5);
        check("t5_e4", intr_out, 8'h00);
        cycles(1);
        check("t5_e5", intr_out, 8'h20);
        watch(5, 30, r, h);
        check("t5_single", r, 0);
        check("t5_width", h, 1);

        // All channels fired on the same edge.
        req_in = 8'h00;
        cycles(30);
        req_in = 8'hFF;
        cycles(5);
        check("all_e4", intr_out, 8'h00);
        cycles(1);
        check("all_e5", intr_out, 8'hFF);
        cycles(1);
        check("all_e6", intr_out, 8'hFF);
        cycles(1);
        check("all_e7", intr_out, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/intr_conditioner.md
# intr_conditioner

Conditions external interrupt request lines before they reach the CPU core's 8-bit interrupt input.
- Each channel is synchronized, debounced and rising-edge detected.
- Each detected edge becomes one fixed-width interrupt pulse, with a guaranteed hold-off gap between pulses on the same channel.
- One event per channel is queued while a pulse or hold-off is in progress; events beyond that are flagged as overruns.
- Sits directly upstream of the CPU: `intr_out` connects to the core's `intr_in`.

## Interface
Parameters:
- `N_CH`, 8: number of channels; must match the CPU interrupt input width.
- `SYNC_STAGES`, 2: synchronizer flops per channel; ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a synchronized level must differ from the filtered level before the filtered level changes; ≥1.
- `PULSE_CYCLES`, 2: width of each `intr_out` pulse in cycles; ≥1.
- `HOLDOFF_CYCLES`, 8: minimum low cycles after a pulse before the next pulse on that channel; ≥1.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-low reset.
- `req_in`  in  N_CH  raw external requests; asynchronous to `clk`.
- `enable`  in  N_CH  per-channel enable; synchronous to `clk`.
- `clr_overrun`  in  N_CH  one-cycle pulse; clears the matching `overrun` bit.
- `intr_out`  out  N_CH  conditioned interrupt pulses to the CPU.
- `pending`  out  N_CH  one event queued on that channel.
- `overrun`  out  N_CH  sticky flag: an event was dropped.

## Operation
- Channels are fully independent. All descriptions below are per channel `i`.
- Sync: `req_in[i]` passes through `SYNC_STAGES` flops. The last stage is `s`.
- Debounce:
  - Filtered level `f` and counter `cnt` are both 0 at reset.
  - If `s == f`: `cnt` is set to 0.
  - If `s != f` and `cnt == DEBOUNCE_CYCLES-1`: `f` takes the value of `s` and `cnt` is set to 0.
  - Otherwise: `cnt` increments.
- Event: the clock edge at which `f` goes 0→1 while `enable[i]` is 1. Falling transitions of `f` never produce events.
- FSM states: `IDLE`, `PULSE`, `HOLDOFF`. `intr_out[i]` is 1 only in `PULSE`.
  - `IDLE` + event → `PULSE`, pulse counter loaded.
  - `PULSE` → `HOLDOFF` after exactly `PULSE_CYCLES` cycles.
  - `HOLDOFF` → after exactly `HOLDOFF_CYCLES` cycles:
    - `PULSE` if `pending` is set; `pending` is cleared on the same edge.
    - `IDLE` otherwise.
  - Event in `PULSE` or `HOLDOFF` with `pending` = 0 → `pending` is set.
  - Event with `pending` = 1 → `overrun` is set. The queue depth stays 1.
- `enable[i]` = 0:
  - Blocks new events.
  - Clears `pending` on that edge.
  - Does not truncate a pulse or hold-off already in progress.
- Simultaneous `clr_overrun[i]` and an overrun event on the same edge: the set wins and `overrun` stays 1.
- Reset (any time, including mid-pulse):
  - All outputs go to 0 immediately, as do `f`, `cnt` and the sync flops.
  - FSM returns to `IDLE`.
  - If `req_in` is high when reset is released, it is debounced and produces one event.

## Timing
- Latency: `req_in` goes high before edge E0 and stays high. With defaults, `intr_out` rises after E5, i.e. after `SYNC_STAGES + DEBOUNCE_CYCLES` edges counting E0.
- Glitch rejection: a synchronized high shorter than `DEBOUNCE_CYCLES` cycles produces no event and leaves `f` unchanged.
- Minimum period of back-to-back pulses on one channel: `PULSE_CYCLES + HOLDOFF_CYCLES` cycles.
- Outputs are registered. There are no combinational paths from inputs to outputs.
- Counter widths: `$clog2(max(value,2))` bits for each count.

## Structure
- Package `intr_pkg` contains:
  - the FSM state typedef (`IDLE`, `PULSE`, `HOLDOFF`);
  - default parameter constants.
- Sub-module `intr_channel` implements one channel: sync, debounce, FSM, pending and overrun.
- `intr_conditioner` instantiates `N_CH` copies of `intr_channel` with a generate loop and concatenates their outputs.

## Test plan
- Reset and basic pulse: release reset with `req_in` = 0.
  - Then set `req_in[0]` = 1 before edge E0.
  - Required: `intr_out[0]` = 1 after E5 and for exactly 2 cycles.
  - Required: all other outputs stay 0.
- Glitch rejection: drive `req_in[3]` high for 3 cycles, then low.
  - Required: `intr_out[3]` never goes high.
  - Required: a 4-cycle high (post-sync) produces exactly one pulse.
- Pending and overrun on channel 1:
  - Toggle `req_in[1]` to produce event A, then event B during `HOLDOFF`, then event C while `pending` = 1.
  - Required: B's pulse starts exactly 10 cycles after A's pulse starts.
  - Required: `overrun[1]` = 1 and stays set.
  - Then a `clr_overrun[1]` pulse alone → `overrun[1]` = 0.
  - Then simultaneous clear and overrun event → `overrun[1]` = 1.
- Enable masking:
  - With `enable[2]` = 0, an event on channel 2 gives no pulse.
  - Set `pending[2]` = 1, then deassert `enable[2]` → `pending[2]` clears and no further pulse is issued.
- Reset mid-pulse: assert `reset` = 0 during `PULSE` on channel 5.
  - Required: `intr_out[5]`, `pending` and `overrun` are all 0 immediately.
  - Then release reset with `req_in[5]` held high → exactly one pulse, after E5.
- Independence: fire all 8 channels on the same edge.
  - Required: all 8 `intr_out` bits rise together and fall together after 2 cycles.
